// File: rtl/code_entry_pkg.sv
// Shared sizes, types and slot-to-output mapping for the digit-entry front end.
package code_entry_pkg;

    localparam int unsigned MAX_DIGITS  = 8;
    localparam int unsigned USER_DIGITS = 4;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned COUNT_W     = 4;
    localparam int unsigned SLOT_W      = $clog2(MAX_DIGITS);

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [SLOT_W-1:0]  slot_t;

    typedef enum logic [1:0] {
        OpNone,
        OpEnter,
        OpBack,
        OpClear
    } op_e;

    // Output nibble n of each group shows the slot entered (3-n)-th within that group.
    function automatic slot_t user_slot(input int unsigned n);
        return slot_t'(USER_DIGITS - 1 - n);
    endfunction

    function automatic slot_t pass_slot(input int unsigned n);
        return slot_t'(MAX_DIGITS - 1 - n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: level follows raw only after raw has held a new value for
// DEBOUNCE_CYCLES cycles; pulse is a one-cycle rising-edge strobe of level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= r_level;
            // Any sample agreeing with the current level restarts the stability window.
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign pulse = r_level & ~r_level_prev;

endmodule

// File: rtl/code_entry.sv
// Digit-entry front end: debounced buttons build an 8-digit buffer presented
// to the unlocker; cleared on unlocker resetCount/flag rising edges.
module code_entry
    import code_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digitSw,
    input  logic               btnEnter,
    input  logic               btnBack,
    input  logic               btnClear,
    input  logic               resetCount,
    input  logic               flag,
    output logic [COUNT_W-1:0] inputCount,
    output logic [DIGIT_W-1:0] userNameInput0,
    output logic [DIGIT_W-1:0] userNameInput1,
    output logic [DIGIT_W-1:0] userNameInput2,
    output logic [DIGIT_W-1:0] userNameInput3,
    output logic [DIGIT_W-1:0] passwordInput0,
    output logic [DIGIT_W-1:0] passwordInput1,
    output logic [DIGIT_W-1:0] passwordInput2,
    output logic [DIGIT_W-1:0] passwordInput3,
    output logic               entryFull
);

    logic [2:0] w_unused_levels;
    logic       w_enter_pulse;
    logic       w_back_pulse;
    logic       w_clear_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btnEnter),
        .level (w_unused_levels[0]),
        .pulse (w_enter_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clk   (clk),
        .rst   (rst),
        .raw   (btnBack),
        .level (w_unused_levels[1]),
        .pulse (w_back_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btnClear),
        .level (w_unused_levels[2]),
        .pulse (w_clear_pulse)
    );

    digit_t r_digits [MAX_DIGITS];
    count_t r_count;
    logic   r_rc_prev;
    logic   r_flag_prev;

    digit_t w_digits_next [MAX_DIGITS];
    count_t w_count_next;
    logic   w_flush;
    op_e    w_op;
    slot_t  w_wr_slot;
    slot_t  w_last_slot;

    // unlocker holds resetCount high for long stretches, so only its edge may clear.
    assign w_flush     = (resetCount & ~r_rc_prev) | (flag & ~r_flag_prev);
    assign w_wr_slot   = slot_t'(r_count);
    assign w_last_slot = slot_t'(r_count - 1'b1);

    always_comb begin
        w_op = OpNone;
        if (!flag) begin
            if (w_clear_pulse) begin
                w_op = OpClear;
            end else if (w_back_pulse) begin
                w_op = OpBack;
            end else if (w_enter_pulse) begin
                w_op = OpEnter;
            end
        end
    end

    always_comb begin
        w_digits_next = r_digits;
        w_count_next  = r_count;
        if (w_flush) begin
            w_digits_next = '{default: '0};
            w_count_next  = '0;
        end else begin
            unique case (w_op)
                OpClear: begin
                    w_digits_next = '{default: '0};
                    w_count_next  = '0;
                end
                OpBack: begin
                    if (r_count != '0) begin
                        w_digits_next[w_last_slot] = '0;
                        w_count_next               = r_count - 1'b1;
                    end
                end
                OpEnter: begin
                    if (r_count < count_t'(MAX_DIGITS)) begin
                        w_digits_next[w_wr_slot] = digitSw;
                        w_count_next             = r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits    <= '{default: '0};
            r_count     <= '0;
            r_rc_prev   <= 1'b0;
            r_flag_prev <= 1'b0;
        end else begin
            r_digits    <= w_digits_next;
            r_count     <= w_count_next;
            r_rc_prev   <= resetCount;
            r_flag_prev <= flag;
        end
    end

    assign inputCount     = r_count;
    assign entryFull      = (r_count == count_t'(MAX_DIGITS));
    assign userNameInput0 = r_digits[user_slot(0)];
    assign userNameInput1 = r_digits[user_slot(1)];
    assign userNameInput2 = r_digits[user_slot(2)];
    assign userNameInput3 = r_digits[user_slot(3)];
    assign passwordInput0 = r_digits[pass_slot(0)];
    assign passwordInput1 = r_digits[pass_slot(1)];
    assign passwordInput2 = r_digits[pass_slot(2)];
    assign passwordInput3 = r_digits[pass_slot(3)];

endmodule

// File: tb/tb_code_entry.sv
// Scoreboard bench for code_entry: stimulus pushes cycle-stamped expectations
// from a queue-based digit model; a negedge monitor pops and compares them.
module tb_code_entry;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digitSw = 4'h0;
    logic       btnEnter = 1'b0;
    logic       btnBack = 1'b0;
    logic       btnClear = 1'b0;
    logic       resetCount = 1'b0;
    logic       flag = 1'b0;
    logic [3:0] inputCount;
    logic [3:0] userNameInput0, userNameInput1, userNameInput2, userNameInput3;
    logic [3:0] passwordInput0, passwordInput1, passwordInput2, passwordInput3;
    logic       entryFull;

    code_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .digitSw        (digitSw),
        .btnEnter       (btnEnter),
        .btnBack        (btnBack),
        .btnClear       (btnClear),
        .resetCount     (resetCount),
        .flag           (flag),
        .inputCount     (inputCount),
        .userNameInput0 (userNameInput0),
        .userNameInput1 (userNameInput1),
        .userNameInput2 (userNameInput2),
        .userNameInput3 (userNameInput3),
        .passwordInput0 (passwordInput0),
        .passwordInput1 (passwordInput1),
        .passwordInput2 (passwordInput2),
        .passwordInput3 (passwordInput3),
        .entryFull      (entryFull)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [3:0]  cnt;
        logic        full;
        logic [31:0] nib;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] mq[$];   // digits in entry order
    int         checks = 0;
    int         errors = 0;

    function automatic void push_exp(input int due);
        exp_t e;
        e.due  = due;
        e.cnt  = 4'(mq.size());
        e.full = (mq.size() == 8);
        e.nib  = '0;
        for (int k = 0; k < 8; k++)
            if (k < mq.size()) e.nib[31-4*k -: 4] = mq[k];
        sbq.push_back(e);
    endfunction

    // Monitor: outputs are stable by the falling edge.
    exp_t        mon_e;
    logic [31:0] mon_nib;
    always @(negedge clk) begin
        mon_nib = {userNameInput3, userNameInput2, userNameInput1, userNameInput0,
                   passwordInput3, passwordInput2, passwordInput1, passwordInput0};
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            if (mon_e.due < cyc) begin
                checks++; errors++;
                $display("FAIL stale_expectation due=%0d now=%0d", mon_e.due, cyc);
            end else begin
                checks++;
                if (inputCount !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL inputCount cyc=%0d got=%0d want=%0d", cyc, inputCount,
                             mon_e.cnt);
                end
                checks++;
                if (entryFull !== mon_e.full) begin
                    errors++;
                    $display("FAIL entryFull cyc=%0d got=%b want=%b", cyc, entryFull,
                             mon_e.full);
                end
                checks++;
                if (mon_nib !== mon_e.nib) begin
                    errors++;
                    $display("FAIL digits cyc=%0d got=%h want=%h", cyc, mon_nib, mon_e.nib);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btnEnter = v;
            1: btnBack  = v;
            default: btnClear = v;
        endcase
    endtask

    // which: 0 enter, 1 back, 2 clear. Checks the cycle before and the cycle the
    // effect must first appear.
    task automatic press(input int which, input logic [3:0] d);
        int k;
        digitSw = d;
        set_btn(which, 1'b1);
        k = cyc;
        push_exp(k + DC);
        if (!flag) begin
            case (which)
                0: if (mq.size() < 8) mq.push_back(d);
                1: if (mq.size() > 0) void'(mq.pop_back());
                default: mq.delete();
            endcase
        end
        push_exp(k + DC + 1);
        step(DC + 2);
        set_btn(which, 1'b0);
        step(DC + 2);
    endtask

    task automatic rise_rc();
        resetCount = 1'b1;
        push_exp(cyc);
        mq.delete();
        push_exp(cyc + 1);
        step(1);
    endtask

    initial begin
        int held;
        int r;
        step(1);
        push_exp(cyc);
        step(2);
        rst = 1'b0;
        push_exp(cyc);

        // Back at count 0 is ignored.
        press(1, 4'h0);

        foreach (mq[i]) mq.delete();
        press(0, 4'h1); press(0, 4'h1); press(0, 4'h0); press(0, 4'h0);
        press(0, 4'h1); press(0, 4'h1); press(0, 4'h0); press(0, 4'h0);
        press(0, 4'h7);   // ninth digit ignored

        press(2, 4'h0);
        press(0, 4'hA); press(0, 4'hB); press(0, 4'hC);
        press(1, 4'h0);
        press(0, 4'hD);

        press(0, 4'h3); press(0, 4'h4); press(0, 4'h5); press(0, 4'h6); press(0, 4'h7);
        held = cyc;
        rise_rc();
        press(0, 4'h2); press(0, 4'h9); press(0, 4'hE);
        step(100 - (cyc - held));
        resetCount = 1'b0;
        step(2);
        push_exp(cyc);

        flag = 1'b1;
        push_exp(cyc);
        mq.delete();
        push_exp(cyc + 1);
        step(1);
        press(0, 4'h8);   // discarded while flag high
        press(2, 4'h0);
        flag = 1'b0;
        step(1);
        press(0, 4'h5);

        // Bounce in 3-cycle bursts never satisfies the 4-cycle window.
        for (int b = 0; b < 3; b++) begin
            btnEnter = (b % 2 == 0);
            step(3);
        end
        btnEnter = 1'b0;
        step(DC + 2);
        push_exp(cyc);

        for (int i = 0; i < 5; i++) press(0, 4'(i + 2));
        // Reset mid-debounce with count 6; held button must re-qualify afterwards.
        digitSw = 4'h6;
        btnEnter = 1'b1;
        step(2);
        rst = 1'b1;
        push_exp(cyc);
        step(1);
        rst = 1'b0;
        mq.delete();
        push_exp(cyc);
        push_exp(cyc + DC);
        mq.push_back(4'h6);
        push_exp(cyc + DC + 1);
        step(DC + 3);
        btnEnter = 1'b0;
        step(DC + 2);

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                press(0, 4'($urandom_range(0, 15)));
            end else if (r <= 7) begin
                press(1, 4'($urandom_range(0, 15)));
            end else if (r == 8) begin
                press(2, 4'($urandom_range(0, 15)));
            end else begin
                rise_rc();
                step(2);
                resetCount = 1'b0;
                step(1);
            end
        end

        step(4);
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending_expectations got=%0d want=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/code_entry.md
# code_entry

Digit-entry front end for the lock: debounces the entry buttons, collects up to eight 4-bit digits from the digit switches, and presents them to `unlocker` as `userNameInput0..3`, `passwordInput0..3` and `inputCount`. Sits directly upstream of `unlocker` and consumes its `resetCount` and `flag` outputs to know when the buffer has been used and must be cleared.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a raw button must be stable before its debounced level changes.
- `clk  in  1`: system clock, all state on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `digitSw  in  4`: digit value from switches, any value 0x0-0xF accepted.
- `btnEnter  in  1`: raw button, commit `digitSw` as next digit.
- `btnBack  in  1`: raw button, delete last digit.
- `btnClear  in  1`: raw button, discard all digits.
- `resetCount  in  1`: from `unlocker`; rising edge = entry consumed.
- `flag  in  1`: from `unlocker`; rising edge = failed attempt.
- `inputCount  out  4`: digits held, 0..8.
- `userNameInput0..3  out  4 each`: digits 1-4; first digit entered in `userNameInput3`, fourth in `userNameInput0`.
- `passwordInput0..3  out  4 each`: digits 5-8; fifth in `passwordInput3`, eighth in `passwordInput0`.
- `entryFull  out  1`: high iff `inputCount == 8`.

## Operation
- Each raw button passes through a debouncer, then a rising-edge detector giving a one-cycle pulse per press; holding a button produces exactly one pulse.
- `resetCount` and `flag` are edge-detected with one register each (reset value 0); levels are never used for clearing, since `unlocker` holds `resetCount` high indefinitely.
- Enter pulse, count N < 8: slot N ← `digitSw` sampled that cycle; count ← N+1. At N = 8: ignored.
- Back pulse, count N > 0: slot N-1 ← 0; count ← N-1. At N = 0: ignored.
- Clear pulse, `resetCount` rise, or `flag` rise: count ← 0, all eight slots ← 0.
- While `flag` is high, enter/back/clear pulses are discarded (not queued).
- Same-cycle priority: `rst` > (`resetCount` rise | `flag` rise) > clear pulse > back pulse > enter pulse; only the highest acts.
- Slot index k (0..7) maps to: k=0→`userNameInput3` … k=3→`userNameInput0`, k=4→`passwordInput3` … k=7→`passwordInput0`.
- Reset values: `inputCount` 0, all digit outputs 0, `entryFull` 0, debouncer levels 0, edge registers 0.

## Timing
- Raw button stable from cycle t: debounced level rises at t+`DEBOUNCE_CYCLES`; pulse in that cycle; outputs update at t+`DEBOUNCE_CYCLES`+1.
- Bounce shorter than `DEBOUNCE_CYCLES` restarts the debouncer counter; no pulse.
- `resetCount`/`flag` rise at cycle t: outputs cleared at t+1.
- Outputs are registered; no combinational path from inputs to outputs.
- `rst` mid-debounce clears counters; a button still held after reset must go stable again for a full `DEBOUNCE_CYCLES` before pulsing.

## Structure
- `code_entry_pkg`: `MAX_DIGITS = 8`, `USER_DIGITS = 4`, `DIGIT_W = 4`, `COUNT_W = 4`, digit type, slot-to-output mapping constants.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `raw`, `level`, `pulse`), instantiated three times.
- Top holds an 8-entry digit array, the count register and two edge registers.

## Test plan
- `DEBOUNCE_CYCLES = 4`. Enter 1,1,0,0,1,1,0,0 -> `inputCount` 8, `entryFull` 1, user nibbles {3..0} = 1,1,0,0, password nibbles same.
- Enter 9th digit at count 8 -> no change; back at count 0 -> count stays 0.
- Enter A,B,C, back, enter D -> count 3, `userNameInput3` = A, `userNameInput2` = B, `userNameInput1` = D, `userNameInput0` = 0.
- Eight digits then `resetCount` high and held for 100 cycles -> count 0 one cycle after rise; new digits accepted while it stays high.
- `flag` rise -> cleared; enter pulses while `flag` high ignored; after `flag` falls, enter 5 -> count 1, `userNameInput3` = 5.
- Button bouncing 1-0-1 in 3-cycle bursts -> no pulse; `rst` asserted with count 6 -> all outputs 0 next cycle.
